// File: rtl/ram_responder.sv
// ram_responder: line-wide backing RAM with fixed per-direction latency and a one-cycle ack.
// Define RAM_LATENCY_JITTER_EN to add 0..3 LFSR-driven cycles of latency per request.
module ram_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 6
) (
    input  logic              clk,
    input  logic              not_reset,
    input  logic              ram_avalid,
    input  logic              ram_rnw,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              ram_ack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t state, state_d;
    logic [4:0] cnt;
    logic req_rnw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
    logic accept, fire;
    logic [1:0] jitter;
`ifdef RAM_LATENCY_JITTER_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge not_reset)
        if (!not_reset) lfsr <= 8'hA5;
        else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign jitter = lfsr[1:0];
`else
    assign jitter = 2'd0;
`endif
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                accept  = ram_avalid;
                state_d = ram_avalid ? WAIT : IDLE;
            end
            WAIT: begin
                fire    = ram_avalid && cnt == '0;
                state_d = !ram_avalid ? IDLE : fire ? ACK : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_rnw   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
        end else begin
            state   <= state_d;
            ram_ack <= fire;
            if (accept) begin
                req_rnw   <= ram_rnw;
                req_addr  <= ram_addr;
                req_wdata <= ram_wdata;
                cnt       <= 5'((ram_rnw ? READ_LAT : WRITE_LAT) - 1) + 5'(jitter);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 5'd1;
            end
            if (fire && req_rnw) ram_rdata <= mem[req_addr];
        end
    end
    // Storage has no reset so contents survive not_reset; writes commit only at the ack edge.
    always_ff @(posedge clk)
        if (fire && !req_rnw) mem[req_addr] <= req_wdata;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder; monitor checks ack timing and read data.
module tb_ram_responder;
    localparam int ADDR_W = 8, DATA_W = 32, READ_LAT = 4, WRITE_LAT = 6;
    logic clk = 0, not_reset = 0, ram_avalid = 0, ram_rnw = 0;
    logic [ADDR_W-1:0] ram_addr = '0;
    logic [DATA_W-1:0] ram_wdata = '0;
    logic [DATA_W-1:0] ram_rdata;
    logic ram_ack, busy;

    ram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
        .clk(clk), .not_reset(not_reset), .ram_avalid(ram_avalid), .ram_rnw(ram_rnw),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_ack(ram_ack), .busy(busy));

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [DATA_W-1:0] data; } exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0, n = 0, errs = 0, last_ack = -10;
    logic [DATA_W-1:0] model [256];
    logic [DATA_W-1:0] last_rd;
    logic prev_ack = 1'b0;
`ifdef RAM_LATENCY_JITTER_EN
    logic [7:0] m_lfsr = 8'hA5;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input logic rnw);
        int l;
        l = rnw ? READ_LAT : WRITE_LAT;
`ifdef RAM_LATENCY_JITTER_EN
        l += int'(m_lfsr[1:0]);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        return l;
    endfunction

    function automatic int next_e0();
        return (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
    endfunction

    // Monitor: every ack must match the head of the scoreboard in cycle and data.
    always @(negedge clk) begin
        if (ram_ack) begin
            chk("ack_one_cycle", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                n++;
                errs++;
                $display("FAIL unexpected_ack at cycle %0d: got ack=1, expected ack=0", cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("rdata", ram_rdata, e.data);
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            n++;
            errs++;
            $display("FAIL ack_timeout at cycle %0d: got no ack, expected ack at cycle %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        prev_ack = ram_ack;
    end

    task automatic req(input logic rnw, input logic [7:0] addr, input logic [31:0] wdata,
                       input bit keep, input bit wiggle);
        int e0, lat, tgt;
        e0  = next_e0();
        lat = lat_of(rnw);
        tgt = e0 + lat;
        if (rnw) last_rd = model[addr];
        else model[addr] = wdata;
        e.cyc  = tgt;
        e.data = last_rd;
        sb.push_back(e);
        ram_avalid = 1; ram_rnw = rnw; ram_addr = addr; ram_wdata = wdata;
        if (wiggle && lat > 1) begin
            while (cyc < e0 + 1) begin @(posedge clk); #1; end
            ram_rnw = ~rnw; ram_addr = ~addr; ram_wdata = ~wdata;
        end
        while (cyc < tgt) begin @(posedge clk); #1; end
        last_ack = tgt;
        if (!keep) ram_avalid = 0;
    endtask

    task automatic abort_req(input logic rnw, input logic [7:0] addr, input logic [31:0] wdata);
        int e0;
        e0 = next_e0();
        void'(lat_of(rnw));
        ram_avalid = 1; ram_rnw = rnw; ram_addr = addr; ram_wdata = wdata;
        while (cyc < e0 + 2) begin @(posedge clk); #1; end
        ram_avalid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", ram_rdata, last_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        int e0;
        foreach (model[i]) model[i] = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ram_ack), 32'd0);
        chk("rst_rdata", ram_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        not_reset = 1;
        req(0, 8'h10, 32'hDEADBEEF, 0, 0);
        req(1, 8'h10, 32'h0, 0, 0);
        req(0, 8'h21, 32'h12345678, 0, 0);
        req(0, 8'h20, 32'hAAAA5555, 1, 0);
        req(1, 8'h21, 32'h0, 0, 0);
        req(0, 8'h05, 32'h00000505, 0, 0);
        req(1, 8'h05, 32'h0, 0, 0);
        abort_req(1, 8'h05, 32'h0);
        req(0, 8'h06, 32'h00000066, 0, 0);
        abort_req(0, 8'h06, 32'h00000BAD);
        req(1, 8'h06, 32'h0, 0, 0);
        req(0, 8'h30, 32'h11111111, 0, 0);
        // Reset lands mid-WAIT of a second write to 8'h30.
        e0 = next_e0();
        void'(lat_of(0));
        ram_avalid = 1; ram_rnw = 0; ram_addr = 8'h30; ram_wdata = 32'h22222222;
        while (cyc < e0 + 1) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        not_reset = 0;
        ram_avalid = 0;
        @(negedge clk);
        chk("midrst_ack", 32'(ram_ack), 32'd0);
        chk("midrst_rdata", ram_rdata, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        not_reset = 1;
        last_rd = '0;
`ifdef RAM_LATENCY_JITTER_EN
        m_lfsr = 8'hA5;
`endif
        req(1, 8'h30, 32'h0, 0, 0);
        req(1, 8'h10, 32'h0, 0, 0);
        req(1, 8'h10, 32'h0, 0, 1);
        req(0, 8'h40, 32'h00004040, 0, 1);
        req(1, 8'h40, 32'h0, 0, 0);
        req(1, 8'hBF, 32'h0, 0, 0);
        for (int i = 0; i < 10; i++) req(1, 8'(i), 32'h0, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL pending_acks: got %0d outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Main-memory responder on the cache-to-RAM port: accepts one line-wide read or write request per handshake from the cache controller (`ram_avalid`/`ram_rnw`), models fixed per-direction access latency, and answers with a one-cycle `ram_ack`. It sits below the cache control unit as the far end of its RAM interface and serves as both the simulation memory and the synthesizable backing store.

## Interface
- `ADDR_W`, 8: line address width; storage depth is 2**ADDR_W lines.
- `DATA_W`, 32: line width in bits.
- `READ_LAT`, 4: read latency in cycles, legal 1..15.
- `WRITE_LAT`, 6: write latency in cycles, legal 1..15.
- `clk`  in  1  clock, rising edge.
- `not_reset`  in  1  reset, asynchronous, active-low.
- `ram_avalid`  in  1  request valid; held high by the initiator until `ram_ack`.
- `ram_rnw`  in  1  1 = read, 0 = write; sampled only on acceptance.
- `ram_addr`  in  ADDR_W  line address; sampled only on acceptance.
- `ram_wdata`  in  DATA_W  write line; sampled only on acceptance.
- `ram_rdata`  out  DATA_W  read line; valid while `ram_ack`=1 for a read.
- `ram_ack`  out  1  one-cycle completion pulse, registered.
- `busy`  out  1  high in WAIT and ACK.

## Operation
- States: IDLE, WAIT, ACK; 5-bit down-counter `cnt`; request registers `req_rnw`, `req_addr`, `req_wdata`.
- IDLE: `ram_avalid`=1 at an edge -> latch rnw/addr/wdata, `cnt` <= (rnw ? READ_LAT : WRITE_LAT) - 1 + jitter, go WAIT. Otherwise stay.
- WAIT: `ram_avalid`=0 -> abort: go IDLE, no ack, write not committed, `ram_rdata` unchanged. Else if `cnt`=0 -> perform access (read: `ram_rdata` <= mem[req_addr]; write: mem[req_addr] <= req_wdata), `ram_ack` <= 1, go ACK. Else `cnt` <= `cnt`-1.
- ACK: `ram_ack` <= 0, go IDLE unconditionally; `ram_avalid` ignored in this state.
- Changes of `ram_rnw`/`ram_addr`/`ram_wdata` while in WAIT are ignored (latched request wins).
- `ram_avalid` high in IDLE is always a new request; the initiator must update rnw/addr/data on the edge it sees `ram_ack`.
- Write ack: `ram_rdata` holds its previous value.
- Storage: 2**ADDR_W x DATA_W array, zero-initialized at time 0, NOT cleared by `not_reset`.

## Timing
- Reset values: state IDLE, `ram_ack`=0, `ram_rdata`=0, `busy`=0, `cnt`=0; pending request discarded, in-flight write not committed.
- Request accepted at edge E0; `ram_ack` rises at edge E0+LAT(+jitter), stays high exactly one cycle.
- Read data and write commit both occur at the ack edge; a read of the same address issued after a write ack returns the new line.
- Back-to-back: next request accepted no earlier than 2 edges after the ack edge (ACK cycle + IDLE sample); with `ram_avalid` held high across, the second request (e.g. write-back then refill) is accepted at E_ack+2.
- Reset deasserted mid-WAIT with `ram_avalid` still high: request is re-accepted fresh from IDLE at the first clock edge.

## Configuration
- `RAM_LATENCY_JITTER_EN` defined: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances once per accepted request; jitter = lfsr[1:0] (value before advance), adding 0..3 cycles to that request's latency.
- Undefined: jitter = 0, LFSR not instantiated; latency exactly READ_LAT/WRITE_LAT.

## Test plan
- Write addr 8'h10, data 32'hDEADBEEF, jitter off -> `ram_ack` one cycle at E0+6; then read 8'h10 -> `ram_ack` at E0+4, `ram_rdata`=32'hDEADBEEF.
- Write-back then refill with `ram_avalid` held high, rnw 0->1 on ack edge, addr 8'h20 then 8'h21 -> two acks, second accepted at E_ack+2, read returns mem[8'h21].
- Abort: read 8'h05 accepted, drop `ram_avalid` at E0+2 -> no ack, `busy`=0 at E0+3; write aborted likewise leaves mem unchanged (verified by later read).
- Reset pulse mid-WAIT of a write to 8'h30 -> `ram_ack`=0, `ram_rdata`=0, mem[8'h30] unchanged; contents written earlier survive reset.
- Change `ram_addr` and `ram_rnw` during WAIT -> ack and data correspond to the originally latched request.
- With `RAM_LATENCY_JITTER_EN`, READ_LAT=1: ten reads -> each ack latency in 1..4, sequence matches LFSR from seed 8'hA5, repeatable after reset.
